// File: rtl/class0_unary_gen_if.sv
// Count-in / thermometer-out bundle for class0_unary_gen.
// The master offers counts and consumes the serial stream; the slave is the generator.
interface class0_unary_gen_if #(
    parameter int N     = 7,
    parameter int CNT_W = $clog2(N + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [CNT_W-1:0] in_count;
    logic [N-1:0]     vec;
    logic             vec_valid;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_bit;
    logic             ser_last;
    logic             sat;

    modport master (
        output in_valid, in_count, ser_ready,
        input  in_ready, vec, vec_valid, ser_valid, ser_bit, ser_last, sat
    );

    modport slave (
        input  in_valid, in_count, ser_ready,
        output in_ready, vec, vec_valid, ser_valid, ser_bit, ser_last, sat
    );
endinterface

// File: rtl/class0_unary_gen.sv
// Regenerates an N-bit thermometer word from a count and streams it bit 0 first.
// A new count is taken on the last beat so back-to-back frames have no bubble.
module class0_unary_gen #(
    parameter int N     = 7,
    parameter int CNT_W = $clog2(N + 1)
) (
    input logic              clk,
    input logic              rst_n,
    class0_unary_gen_if.slave bus
);
    localparam int                 IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(N);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_inc_s;
    logic [N-1:0]     vec_r;
    logic [N-1:0]     load_vec_s;
    logic             vec_valid_r;
    logic             ser_valid_r;
    logic             ser_bit_r;
    logic             ser_last_r;
    logic             sat_r;
    logic             in_ready_s;
    logic             accept_s;
    logic             beat_s;
    logic             last_idx_s;
    logic             last_beat_s;
    logic             over_s;
    logic [CNT_W-1:0] cnt_s;

    // Bit k is set exactly when k lies below the requested count.
    function automatic logic [N-1:0] thermometer(input logic [CNT_W-1:0] cnt);
        logic [N-1:0] word;
        word = {N{1'b0}};
        for (int k = 0; k < N; k++) begin
            if (CNT_W'(k) < cnt) begin
                word[k] = 1'b1;
            end else begin
                word[k] = 1'b0;
            end
        end
        return word;
    endfunction

    // Beat bookkeeping and clamping of the offered count.
    always_comb begin
        beat_s      = ser_valid_r && bus.ser_ready;
        last_idx_s  = (idx_r == IDX_LAST);
        last_beat_s = beat_s && last_idx_s;
        idx_inc_s   = idx_r + IDX_ONE;
        if (bus.in_count > CNT_MAX) begin
            over_s = 1'b1;
            cnt_s  = CNT_MAX;
        end else begin
            over_s = 1'b0;
            cnt_s  = bus.in_count;
        end
        load_vec_s = thermometer(cnt_s);
    end

    // Next-state and input-side ready.
    always_comb begin
        state_nxt_s = state_r;
        in_ready_s  = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (bus.in_valid) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                // Only the final beat of a frame can overlap with loading the next one.
                in_ready_s = bus.ser_ready && last_idx_s;
                if (last_beat_s && !bus.in_valid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                in_ready_s  = 1'b0;
            end
        endcase
        accept_s = bus.in_valid && in_ready_s;
    end

    // Frame registers: load on accept, advance on each beat, drop valid after the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= {IDX_W{1'b0}};
            vec_r       <= {N{1'b0}};
            vec_valid_r <= 1'b0;
            ser_valid_r <= 1'b0;
            ser_bit_r   <= 1'b0;
            ser_last_r  <= 1'b0;
            sat_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                vec_r       <= load_vec_s;
                idx_r       <= {IDX_W{1'b0}};
                vec_valid_r <= 1'b1;
                ser_valid_r <= 1'b1;
                ser_bit_r   <= load_vec_s[0];
                ser_last_r  <= 1'b0;
            end else if (last_beat_s) begin
                idx_r       <= {IDX_W{1'b0}};
                vec_valid_r <= 1'b0;
                ser_valid_r <= 1'b0;
                ser_bit_r   <= 1'b0;
                ser_last_r  <= 1'b0;
            end else if (beat_s) begin
                idx_r      <= idx_inc_s;
                ser_bit_r  <= vec_r[idx_inc_s];
                ser_last_r <= (idx_inc_s == IDX_LAST);
            end
            if (accept_s && over_s) begin
                sat_r <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.vec       = vec_r;
    assign bus.vec_valid = vec_valid_r;
    assign bus.ser_valid = ser_valid_r;
    assign bus.ser_bit   = ser_bit_r;
    assign bus.ser_last  = ser_last_r;
    assign bus.sat       = sat_r;
endmodule
